// File: rtl/gate_io_pkg.sv
// Shared types and helpers for the push-button conditioning block.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package gate_io_pkg;

    // Number of push-button channels. Bit 0 feeds gate in1, bit 1 feeds in2.
    localparam int NUM_KEYS = 2;

    // One bit per key channel.
    typedef logic [NUM_KEYS-1:0] key_vec_t;

    // Width of a counter that must hold 0 .. value-1.
    // $clog2(1) is 0, so the result is clamped to at least one bit.
    function automatic int clog2_min1(input int value);
        int w;
        w = $clog2(value);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : gate_io_pkg

// File: rtl/dual_key_debounce_if.sv
// Bundle of key inputs and conditioned outputs for the dual-key debouncer.
// Latency: n/a (wiring only).
// Backpressure: none; every signal is a plain level or pulse.
//
// Signals:
//   key_raw    raw asynchronous button pins (polarity set by the debouncer)
//   key_out    debounced level per key, 1 = pressed
//   press_p    1-cycle pulse when key_out rises
//   release_p  1-cycle pulse when key_out falls
// Modports:
//   master     the side that owns the buttons and consumes the results
//   slave      the debouncer itself
interface dual_key_debounce_if;
    import gate_io_pkg::*;

    key_vec_t key_raw;
    key_vec_t key_out;
    key_vec_t press_p;
    key_vec_t release_p;

    modport master (
        output key_raw,
        input  key_out,
        input  press_p,
        input  release_p
    );

    modport slave (
        input  key_raw,
        output key_out,
        output press_p,
        output release_p
    );

endinterface : dual_key_debounce_if

// File: rtl/debounce_channel.sv
// One key: polarity normalise, 2-FF synchroniser, stable-count filter, edge pulses.
// Latency: level changes DEBOUNCE_CYCLES+1 edges after the first s1 capture.
// Backpressure: none; outputs are free-running registers.
//
// Ports:
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   raw      asynchronous button pin
//   level    debounced level, 1 = pressed
//   rise_p   1-cycle pulse on the first cycle level is 1
//   fall_p   1-cycle pulse on the first cycle level is 0
module debounce_channel
    import gate_io_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter bit          RAW_ACTIVE_LOW  = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise_p,
    output logic fall_p
);

    // Counter holds 0 .. DEBOUNCE_CYCLES-1; the terminal value is where a
    // change is accepted, so the counter never needs to reach DEBOUNCE_CYCLES.
    localparam int              CNT_W    = clog2_min1(int'(DEBOUNCE_CYCLES));
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 16'd1);

    // Normalised key: 1 = pressed regardless of button wiring.
    logic             key_norm;
    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;

    assign key_norm = raw ^ RAW_ACTIVE_LOW;

    // The synchroniser holds normalised values, so clearing it to 0 puts it
    // at the "not pressed" idle level whatever the pin polarity is.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            cnt    <= '0;
            level  <= 1'b0;
            rise_p <= 1'b0;
            fall_p <= 1'b0;
        end else begin
            s1     <= key_norm;
            s2     <= s1;
            rise_p <= 1'b0;
            fall_p <= 1'b0;

            if (s2 == level) begin
                // Any sample agreeing with the current level restarts the
                // stability window, which is what rejects bounce.
                cnt <= '0;
            end else if (cnt == CNT_TERM) begin
                // DEBOUNCE_CYCLES consecutive differing samples: accept.
                level  <= s2;
                cnt    <= '0;
                rise_p <= s2;
                fall_p <= ~s2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // A channel can only move in one direction per edge.
    a_pulse_exclusive : assert property (
        @(posedge clk) disable iff (!rst_n) !(rise_p && fall_p)
    );

    // Pulses coincide with the level they announce.
    a_rise_level : assert property (
        @(posedge clk) disable iff (!rst_n) rise_p |-> level
    );

    a_fall_level : assert property (
        @(posedge clk) disable iff (!rst_n) fall_p |-> !level
    );

endmodule : debounce_channel

// File: rtl/dual_key_debounce.sv
// Conditions two raw push-buttons into clean levels plus press/release pulses.
// Latency: key_out changes DEBOUNCE_CYCLES+1 edges after the first sync capture.
// Backpressure: none; outputs are registers updated every clk edge.
//
// Ports:
//   clk    system clock, sole clock domain
//   rst_n  asynchronous active-low reset (release synchronised by the user)
//   io     slave side of dual_key_debounce_if:
//            key_raw   in   raw button pins, polarity per RAW_ACTIVE_LOW
//            key_out   out  debounced level, bit 0 -> in1, bit 1 -> in2
//            press_p   out  1-cycle pulse on key_out 0->1
//            release_p out  1-cycle pulse on key_out 1->0
//
// DEBOUNCE_CYCLES must be at least 1.
module dual_key_debounce
    import gate_io_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter bit          RAW_ACTIVE_LOW  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dual_key_debounce_if.slave   io
);

    key_vec_t level;
    key_vec_t rise;
    key_vec_t fall;

    // Channels share nothing but clock and reset, so simultaneous presses
    // simply produce simultaneous pulses.
    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RAW_ACTIVE_LOW  (RAW_ACTIVE_LOW)
        ) u_channel (
            .clk    (clk),
            .rst_n  (rst_n),
            .raw    (io.key_raw[g]),
            .level  (level[g]),
            .rise_p (rise[g]),
            .fall_p (fall[g])
        );
    end

    assign io.key_out   = level;
    assign io.press_p   = rise;
    assign io.release_p = fall;

endmodule : dual_key_debounce
